// File: rtl/awg_btn_cmd_ctrl.sv
// rtl/awg_btn_cmd_ctrl.sv - front-panel button command controller; optional hold-to-repeat with AWG_BTN_AUTOREPEAT_EN
module awg_btn_cmd_ctrl #(
   parameter int NUM_WAVES     = 4,
   parameter int AMP_LEVELS    = 8,
   parameter int FREQ_W        = 16,
   parameter int FREQ_MIN      = 1,
   parameter int FREQ_MAX      = 65535,
   parameter int FREQ_STEP     = 16,
   parameter int FREQ_INIT     = 1000,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    btn_pulse,
   input  logic [3:0]                    btn_level,
   input  logic                          cfg_ready,
   output logic                          cfg_valid,
   output logic [$clog2(NUM_WAVES)-1:0]  wave_sel,
   output logic [FREQ_W-1:0]             freq_word,
   output logic [$clog2(AMP_LEVELS)-1:0] amp_sel,
   output logic                          busy
);
   localparam int WAVE_W = $clog2(NUM_WAVES);
   localparam int AMP_W  = $clog2(AMP_LEVELS);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_ACK = 2'd1;

   localparam logic [WAVE_W-1:0]        WAVE_LAST = WAVE_W'(NUM_WAVES - 1);
   localparam logic [AMP_W-1:0]         AMP_LAST  = AMP_W'(AMP_LEVELS - 1);
   localparam logic [FREQ_W:0]          UP_MAX    = (FREQ_W+1)'(FREQ_MAX);
   localparam logic [FREQ_W:0]          UP_STEP   = (FREQ_W+1)'(FREQ_STEP);
   localparam logic signed [FREQ_W+1:0] DN_MIN    = (FREQ_W+2)'(FREQ_MIN);
   localparam logic signed [FREQ_W+1:0] DN_STEP   = (FREQ_W+2)'(FREQ_STEP);

   logic [1:0]               state;
   logic [1:0]               pick;
   logic [1:0]               applyCmd;
   logic [FREQ_W:0]          upSum;
   logic signed [FREQ_W+1:0] dnDiff;
   logic [WAVE_W-1:0]        nextWave;
   logic [FREQ_W-1:0]        nextFreq;
   logic [AMP_W-1:0]         nextAmp;

`ifdef AWG_BTN_AUTOREPEAT_EN
   localparam logic [1:0] HOLD = 2'd2;
   localparam int MAX_WAIT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] FIRST_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [1:0]       cmdReg;
   logic [CNT_W-1:0] holdCnt;
   logic             firstRep;
   logic             repeatable;

   // repeats re-apply the latched command; a fresh press uses the arbitrated one
   assign applyCmd   = (state == IDLE) ? pick : cmdReg;
   assign repeatable = (cmdReg == 2'd1) || (cmdReg == 2'd2);
`else
   logic unusedInputs;

   assign applyCmd     = pick;
   assign unusedInputs = ^{btn_level, HOLD_CYCLES, REPEAT_CYCLES};
`endif

   assign busy   = (state != IDLE);
   assign upSum  = {1'b0, freq_word} + UP_STEP;
   assign dnDiff = $signed({2'b00, freq_word}) - DN_STEP;

   // fixed priority: lowest set pulse bit wins, the rest are dropped
   always_comb begin
      pick = 2'd0;
      if (btn_pulse[0])      pick = 2'd0;
      else if (btn_pulse[1]) pick = 2'd1;
      else if (btn_pulse[2]) pick = 2'd2;
      else if (btn_pulse[3]) pick = 2'd3;
   end

   // configuration that results from applying the selected command
   always_comb begin
      nextWave = wave_sel;
      nextFreq = freq_word;
      nextAmp  = amp_sel;
      case (applyCmd)
         2'd0:    nextWave = (wave_sel == WAVE_LAST) ? '0 : wave_sel + WAVE_W'(1);
         2'd1:    nextFreq = (upSum > UP_MAX) ? FREQ_W'(FREQ_MAX) : upSum[FREQ_W-1:0];
         2'd2:    nextFreq = (dnDiff < DN_MIN) ? FREQ_W'(FREQ_MIN) : dnDiff[FREQ_W-1:0];
         default: nextAmp  = (amp_sel == AMP_LAST) ? '0 : amp_sel + AMP_W'(1);
      endcase
   end

   // command FSM: accept a press, hold the update until the core takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cfg_valid <= 1'b0;
         wave_sel  <= '0;
         freq_word <= FREQ_W'(FREQ_INIT);
         amp_sel   <= '0;
`ifdef AWG_BTN_AUTOREPEAT_EN
         cmdReg    <= 2'd0;
         holdCnt   <= '0;
         firstRep  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|btn_pulse) begin
                  wave_sel  <= nextWave;
                  freq_word <= nextFreq;
                  amp_sel   <= nextAmp;
                  cfg_valid <= 1'b1;
                  state     <= WAIT_ACK;
`ifdef AWG_BTN_AUTOREPEAT_EN
                  cmdReg    <= pick;
                  firstRep  <= 1'b1;
`endif
               end
            end
            WAIT_ACK: begin
               if (cfg_ready) begin
                  cfg_valid <= 1'b0;
                  state     <= IDLE;
`ifdef AWG_BTN_AUTOREPEAT_EN
                  holdCnt   <= '0;
                  if (repeatable && btn_level[cmdReg]) state <= HOLD;
`endif
               end
            end
`ifdef AWG_BTN_AUTOREPEAT_EN
            HOLD: begin
               if (!btn_level[cmdReg]) begin
                  state   <= IDLE;
                  holdCnt <= '0;
               end else if (holdCnt == (firstRep ? FIRST_LAST : REPEAT_LAST)) begin
                  freq_word <= nextFreq;
                  cfg_valid <= 1'b1;
                  holdCnt   <= '0;
                  firstRep  <= 1'b0;
                  state     <= WAIT_ACK;
               end else begin
                  holdCnt <= holdCnt + CNT_W'(1);
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule
